// File: rtl/inst_encode_loader.sv
// inst_encode_loader: packs assembled instruction fields into 32-bit words and
// streams them into instruction memory at consecutive (wrapping) addresses
// starting from a programmed base. One registered stage between the accepted
// field set and the memory write strobe.
module inst_encode_loader #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W-1:0] base_addr,
    input  logic [ADDR_W:0]   load_len,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [4:0]        mnem,
    input  logic [4:0]        rs,
    input  logic [4:0]        rt,
    input  logic [4:0]        rd,
    input  logic [4:0]        shamt,
    input  logic [15:0]       imm,
    input  logic [25:0]       target,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_FLUSH = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        FMT_R  = 2'd0,
        FMT_I  = 2'd1,
        FMT_J  = 2'd2,
        FMT_JR = 2'd3
    } fmt_t;

    // Returns {illegal, word}; illegal mnemonics encode to an all-zero word.
    function automatic logic [32:0] encode_fields(
        input logic [4:0]  m,
        input logic [4:0]  f_rs,
        input logic [4:0]  f_rt,
        input logic [4:0]  f_rd,
        input logic [4:0]  f_sh,
        input logic [15:0] f_imm,
        input logic [25:0] f_tgt
    );
        logic [5:0]  code;
        fmt_t        fmt;
        logic [4:0]  rs_eff;
        logic        illegal;
        logic [31:0] word;
        code    = 6'd0;
        fmt     = FMT_R;
        rs_eff  = f_rs;
        illegal = 1'b0;
        case (m)
            5'd0:  code = 6'b100000;
            5'd1:  code = 6'b100010;
            5'd2:  code = 6'b100001;
            5'd3:  code = 6'b100011;
            5'd4:  code = 6'b100100;
            5'd5:  code = 6'b100101;
            5'd6:  begin code = 6'b000000; rs_eff = 5'd0; end
            5'd7:  begin code = 6'b000010; rs_eff = 5'd0; end
            5'd8:  code = 6'b101010;
            5'd9:  begin code = 6'b001000; fmt = FMT_I; end
            5'd10: begin code = 6'b001001; fmt = FMT_I; end
            5'd11: begin code = 6'b001100; fmt = FMT_I; end
            5'd12: begin code = 6'b001101; fmt = FMT_I; end
            5'd13: begin code = 6'b100011; fmt = FMT_I; end
            5'd14: begin code = 6'b101011; fmt = FMT_I; end
            5'd15: begin code = 6'b000100; fmt = FMT_I; end
            5'd16: begin code = 6'b000101; fmt = FMT_I; end
            5'd17: begin code = 6'b000111; fmt = FMT_I; end
            5'd18: begin code = 6'b000110; fmt = FMT_I; end
            5'd19: begin code = 6'b001010; fmt = FMT_I; end
            5'd20: begin code = 6'b000010; fmt = FMT_J; end
            5'd21: begin code = 6'b000011; fmt = FMT_J; end
            5'd22: begin code = 6'b001000; fmt = FMT_JR; end
            default: illegal = 1'b1;
        endcase
        case (fmt)
            FMT_R:   word = {6'b000000, rs_eff, f_rt, f_rd, f_sh, code};
            FMT_I:   word = {code, f_rs, f_rt, f_imm};
            FMT_J:   word = {code, f_tgt};
            FMT_JR:  word = {6'b000000, f_rs, 15'd0, code};
            default: word = 32'd0;
        endcase
        if (illegal) begin
            word = 32'd0;
        end else begin
            word = word;
        end
        return {illegal, word};
    endfunction

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W:0]     remain_q;
    logic                in_ready_q;
    logic                mem_we_q;
    logic [ADDR_W-1:0]   mem_addr_q;
    logic [31:0]         mem_wdata_q;
    logic                busy_q;
    logic                done_q;
    logic                err_q;
    logic [32:0]         enc_d;

    // Encode the field set currently presented on the input port.
    always_comb begin
        enc_d = encode_fields(mnem, rs, rt, rd, shamt, imm, target);
    end

    // Session FSM with all outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            addr_q      <= '0;
            remain_q    <= '0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    mem_we_q <= 1'b0;
                    done_q   <= 1'b0;
                    if (start) begin
                        addr_q   <= base_addr;
                        remain_q <= load_len;
                        err_q    <= 1'b0;
                        if (load_len == '0) begin
                            state_q <= ST_DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q    <= ST_LOAD;
                            in_ready_q <= 1'b1;
                            busy_q     <= 1'b1;
                        end
                    end
                end
                ST_LOAD: begin
                    if (in_valid && in_ready_q) begin
                        mem_we_q    <= 1'b1;
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= enc_d[31:0];
                        addr_q      <= addr_q + ADDR_W'(1);
                        remain_q    <= remain_q - (ADDR_W+1)'(1);
                        if (enc_d[32]) begin
                            err_q <= 1'b1;
                        end
                        // Last word of the session: stop accepting, drain.
                        if (remain_q == (ADDR_W+1)'(1)) begin
                            state_q    <= ST_FLUSH;
                            in_ready_q <= 1'b0;
                        end
                    end else begin
                        mem_we_q <= 1'b0;
                    end
                end
                ST_FLUSH: begin
                    mem_we_q <= 1'b0;
                    busy_q   <= 1'b0;
                    done_q   <= 1'b1;
                    state_q  <= ST_DONE;
                end
                ST_DONE: begin
                    mem_we_q <= 1'b0;
                    done_q   <= 1'b0;
                    state_q  <= ST_IDLE;
                end
                default: begin
                    state_q    <= ST_IDLE;
                    in_ready_q <= 1'b0;
                    mem_we_q   <= 1'b0;
                    busy_q     <= 1'b0;
                    done_q     <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule

// File: doc/inst_encode_loader.md
# inst_encode_loader

Instruction encoder and program loader for the processor. It accepts assembled-instruction fields over a valid/ready handshake and packs them into 32-bit instruction words. These are the same formats the instruction decode stage consumes. Each word is written to instruction memory at consecutive addresses starting from a programmed base. The block sits between the host/testbench program source and the instruction memory write port.

## Interface
- ADDR_W, 8, instruction-memory word-address width; addresses wrap modulo 2^ADDR_W
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  begin a load session; sampled only in IDLE
- base_addr  in  ADDR_W  first write address, captured on start
- load_len  in  ADDR_W+1  number of words in session, captured on start
- in_valid  in  1  field set valid
- in_ready  out  1  block can accept a field set
- mnem  in  5  mnemonic id (list below)
- rs, rt, rd, shamt  in  5 each  register/shift fields
- imm  in  16  immediate/offset
- target  in  26  jump target
- mem_we  out  1  instruction-memory write strobe
- mem_addr  out  ADDR_W  write address
- mem_wdata  out  32  encoded word
- busy  out  1  session active (LOAD or FLUSH)
- done  out  1  one-cycle pulse at end of session
- err  out  1  sticky: illegal mnemonic seen this session; cleared on accepted start

## Operation
- Mnemonic ids and encodings (R = {6'b0,rs,rt,rd,shamt,funct}, I = {op,rs,rt,imm}, J = {op,target}):
  - 0 add f100000, 1 sub f100010, 2 addu f100001, 3 subu f100011, 4 and f100100, 5 or f100101, 8 slt f101010: R
  - 6 sll f000000, 7 srl f000010: R with rs forced to 0
  - 9 addi 001000, 10 addiu 001001, 11 andi 001100, 12 ori 001101, 13 lw 100011, 14 sw 101011, 15 beq 000100, 16 bne 000101, 17 bgt 000111, 18 bleq 000110, 19 slti 001010: I
  - 20 j 000010, 21 jal 000011: J
  - 22 jr: {6'b0,rs,15'b0,6'b001000}
  - 23-31 illegal: word = 32'h0000_0000, err set, still counts toward load_len and is still written
- FSM states: IDLE, LOAD, FLUSH, DONE.
  - IDLE: in_ready=0. On start, capture base_addr/load_len, clear err, go to LOAD. If load_len=0, go to DONE instead.
  - LOAD: in_ready=1. Each handshake (in_valid&in_ready) registers the encoded word and increments accept count. On the load_len-th handshake, go to FLUSH.
  - FLUSH: in_ready=0. Final pending write issues; go to DONE.
  - DONE: done=1 for one cycle; go to IDLE.
- Write address starts at base_addr and increments by 1 per written word, wrapping from 2^ADDR_W-1 to 0.
- start outside IDLE is ignored. in_valid outside LOAD is ignored (no handshake).

## Timing
- Reset values: state IDLE; in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, busy=0, done=0, err=0; counters 0.
- Latency: field set accepted at edge N → mem_we=1 with mem_addr/mem_wdata valid during cycle N+1 (one registered stage).
- Throughput: one word per cycle. in_valid held high through LOAD gives back-to-back mem_we.
- mem_we is high exactly once per accepted field set. mem_addr/mem_wdata hold their last values when mem_we=0.
- Session of L≥1 words: start at edge S → LOAD from S+1. With continuous valid, last handshake at S+L. FLUSH in S+L+1 carries the final write. done is high in cycle S+L+2.
- load_len=0: done is high in the cycle after start, with no writes.
- busy=1 in LOAD and FLUSH.
- err asserts in the cycle of the illegal word's mem_we.
- Asynchronous reset mid-session aborts immediately. Outputs go to their reset values, and no further writes occur after deassertion until a new start.

## Test plan
- Reset, start base=0x10 len=3, stream add(rs1,rt2,rd3), addi(rs1,rt2,imm 0x0005), j(target 0x40) → writes 0x10:0x00221820, 0x11:0x20220005, 0x12:0x08000040; done pulses 2 cycles after last handshake; err=0.
- sll rs=7 rt=2 rd=4 shamt=3, and jr rs=31 → rs forced 0: 0x000220C0; jr: 0x03E00008.
- base=0xFE len=4, continuous valid → addresses 0xFE,0xFF,0x00,0x01; mem_we four consecutive cycles.
- mnem=25 mid-stream → 0x00000000 written at its slot, err=1 until next start, total writes still = len.
- Gapped in_valid, start pulsed during LOAD, len=0 session, rst_n low mid-LOAD → no stalls lost, start ignored, done without writes, all outputs at reset values and no write after reset.
